hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the RV32I pipeline. Decodes the ID-stage instruction,
//  tracks in-flight destination registers in a NUM_FWD_STAGES-deep scoreboard (index 0 = EX),
//  and registers per-operand forward selects for the next EX cycle. Generates load-use stalls and
//  taken-branch/jump flushes. Operand selects feed ALU, branch comparator and store-data muxes alike.
// PARAMETERS
//  NUM_FWD_STAGES  2  stages after EX whose results are forwardable (>=1)
//  LOAD_LAT        1  stages past EX before load data is forwardable (0..NUM_FWD_STAGES-1)
//  SELW            $clog2(NUM_FWD_STAGES+1)  derived select width; do not override
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-low reset
//  inst_id      in   32    instruction in ID stage
//  id_valid     in   1     inst_id is a real instruction (0 = bubble)
//  ex_taken     in   1     EX instruction redirects PC (taken branch, JAL, JALR)
//  stall_ext    in   1     external freeze (e.g. memory wait); freezes all state
//  stall_id     out  1     hold PC and ID register this cycle
//  flush_id     out  1     squash ID-stage instruction this cycle
//  rs1_fwd_sel  out  SELW  registered: 0 = regfile, k = result of scoreboard stage k
//  rs2_fwd_sel  out  SELW  registered: same encoding for rs2 (ALU, brcomp, store data)
//  rs1_fwd_ld   out  1     registered: selected rs1 source is load data, not ALU result
//  rs2_fwd_ld   out  1     registered: same for rs2
// BEHAVIOUR
//  Decode: uses_rs1 = opcode not LUI/AUIPC/JAL; uses_rs2 = RTYPE/STORE/BRANCH;
//   has_rd = opcode not STORE/BRANCH/CSR and rd!=0; x0 never matches, never forwarded.
//  Scoreboard entry = {valid, rd, is_load}, indices 0..NUM_FWD_STAGES-1. Retired beyond last
//   index -> regfile (write-before-read assumed), select 0.
//  Match: entry i matches operand when valid, rd==rs, operand used. Youngest (lowest i) wins.
//  Forward: consumer enters EX next cycle, so match at entry i drives sel=i+1, ld=is_load.
//   i+1 > NUM_FWD_STAGES impossible (last entry only reachable by i=N-1 -> sel=N).
//  Load-use: match on load with i < LOAD_LAT -> stall_id=1 combinationally; entry 0 <= bubble;
//   sels <= 0. Stall repeats each cycle until the load shifts far enough (LOAD_LAT-i cycles).
//  Flush: ex_taken -> flush_id=1, entry 0 <= bubble, stall_id=0 (flush beats load-use stall).
//  Normal cycle: entry0 <= {id_valid&has_rd, rd, opcode==LOAD}; entry k <= entry k-1.
//  stall_ext=1: scoreboard and select regs hold; stall_id/flush_id still report combinational
//   values but cause no state change; stall_ext beats flush and stall.
//  Reset (rst=0, async): all entries invalid; sels 0, ld bits 0; stall_id/flush_id 0 once
//   scoreboard empty. Reset mid-stall clears stall on the next evaluation.
//  Latency: selects valid 1 cycle after decode; stall/flush same-cycle combinational.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds out [31:0] stall_cnt, flush_cnt; +1 per non-frozen cycle with
//   stall_id / flush_id; saturate at 32'hFFFF_FFFF; cleared by rst. Undefined: ports absent,
//   no counter logic; all other behaviour identical.
// TESTING
//  add x5,x1,x2 then add x6,x5,x3 (N=2) -> rs1_fwd_sel=1, rs1_fwd_ld=0, no stall.
//  add x5 ; nop ; sub x7,x4,x5 -> rs2_fwd_sel=2; third back (N=2) -> rs2_fwd_sel=0.
//  lw x5 ; add x6,x5,x5 (LOAD_LAT=1) -> stall_id=1 one cycle; then rs1/rs2_fwd_sel=2, ld=1.
//  Same load-use with LOAD_LAT=0 -> no stall, sel=1, ld=1; rd=x0 producer -> sel=0 always.
//  lw x5 ; beq x5,x0 with ex_taken=1 same cycle -> flush_id=1, stall_id=0, entry0 bubble.
//  stall_ext held 3 cycles mid-sequence -> sels/scoreboard unchanged; rst pulse -> sels 0, counters 0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall, taken-branch flush and operand forward
// selection for the RV32I pipeline. A NUM_FWD_STAGES-deep scoreboard (entry 0
// = EX) tracks in-flight destinations; per-operand forward selects are
// registered so they are valid when the ID instruction reaches EX.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_fwd_unit #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int SELW           = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_id,
    input  logic            id_valid,
    input  logic            ex_taken,
    input  logic            stall_ext,
    output logic            stall_id,
    output logic            flush_id,
    output logic [SELW-1:0] rs1_fwd_sel,
    output logic [SELW-1:0] rs2_fwd_sel,
    output logic            rs1_fwd_ld,
    output logic            rs2_fwd_ld
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Scoreboard: entry i = {valid, rd, is_load}; index 0 is the EX stage.
    logic [NUM_FWD_STAGES-1:0]      sb_vld_q, sb_vld_d;
    logic [NUM_FWD_STAGES-1:0][4:0] sb_rd_q,  sb_rd_d;
    logic [NUM_FWD_STAGES-1:0]      sb_ld_q,  sb_ld_d;

    logic [SELW-1:0] rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
    logic            rs1_ld_q,  rs1_ld_d,  rs2_ld_q,  rs2_ld_d;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       uses_rs1, uses_rs2, has_rd, is_load;
    logic [SELW-1:0] sel1_c, sel2_c;
    logic       ld1_c, ld2_c, haz1_c, haz2_c;

    // funct3/funct7/immediate bits play no part in hazard detection
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_id[31:25], inst_id[14:12]};

    // Decode operand usage and destination of the ID-stage instruction
    always_comb begin
        opcode   = inst_id[6:0];
        rd       = inst_id[11:7];
        rs1      = inst_id[19:15];
        rs2      = inst_id[24:20];
        uses_rs1 = id_valid && (rs1 != 5'd0) &&
                   !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        uses_rs2 = id_valid && (rs2 != 5'd0) &&
                   (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        has_rd   = (rd != 5'd0) &&
                   !(opcode == OPC_STORE || opcode == OPC_BRANCH || opcode == OPC_SYSTEM);
        is_load  = (opcode == OPC_LOAD);
    end

    // Scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        sel1_c = '0;
        sel2_c = '0;
        ld1_c  = 1'b0;
        ld2_c  = 1'b0;
        haz1_c = 1'b0;
        haz2_c = 1'b0;
        for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
            if (uses_rs1 && sb_vld_q[i] && (sb_rd_q[i] == rs1)) begin
                sel1_c = SELW'(i + 1);
                ld1_c  = sb_ld_q[i];
                haz1_c = sb_ld_q[i] && (i < LOAD_LAT);
            end
            if (uses_rs2 && sb_vld_q[i] && (sb_rd_q[i] == rs2)) begin
                sel2_c = SELW'(i + 1);
                ld2_c  = sb_ld_q[i];
                haz2_c = sb_ld_q[i] && (i < LOAD_LAT);
            end
        end
    end

    // A redirect squashes the ID instruction, so it overrides a load-use stall
    always_comb begin
        flush_id = ex_taken;
        stall_id = (haz1_c || haz2_c) && !ex_taken;
    end

    // Next state: shift the scoreboard; insert a bubble on stall or flush
    always_comb begin
        sb_vld_d  = sb_vld_q;
        sb_rd_d   = sb_rd_q;
        sb_ld_d   = sb_ld_q;
        rs1_sel_d = rs1_sel_q;
        rs2_sel_d = rs2_sel_q;
        rs1_ld_d  = rs1_ld_q;
        rs2_ld_d  = rs2_ld_q;
        if (!stall_ext) begin
            for (int k = NUM_FWD_STAGES - 1; k >= 1; k--) begin
                sb_vld_d[k] = sb_vld_q[k-1];
                sb_rd_d[k]  = sb_rd_q[k-1];
                sb_ld_d[k]  = sb_ld_q[k-1];
            end
            if (flush_id || stall_id) begin
                sb_vld_d[0] = 1'b0;
                sb_rd_d[0]  = 5'd0;
                sb_ld_d[0]  = 1'b0;
                rs1_sel_d   = '0;
                rs2_sel_d   = '0;
                rs1_ld_d    = 1'b0;
                rs2_ld_d    = 1'b0;
            end else begin
                sb_vld_d[0] = id_valid && has_rd;
                sb_rd_d[0]  = rd;
                sb_ld_d[0]  = is_load;
                rs1_sel_d   = sel1_c;
                rs2_sel_d   = sel2_c;
                rs1_ld_d    = ld1_c;
                rs2_ld_d    = ld2_c;
            end
        end
    end

    // Scoreboard and forward-select registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_vld_q  <= '0;
            sb_rd_q   <= '0;
            sb_ld_q   <= '0;
            rs1_sel_q <= '0;
            rs2_sel_q <= '0;
            rs1_ld_q  <= 1'b0;
            rs2_ld_q  <= 1'b0;
        end else begin
            sb_vld_q  <= sb_vld_d;
            sb_rd_q   <= sb_rd_d;
            sb_ld_q   <= sb_ld_d;
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
            rs1_ld_q  <= rs1_ld_d;
            rs2_ld_q  <= rs2_ld_d;
        end
    end

    assign rs1_fwd_sel = rs1_sel_q;
    assign rs2_fwd_sel = rs2_sel_q;
    assign rs1_fwd_ld  = rs1_ld_q;
    assign rs2_fwd_ld  = rs2_ld_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating event counters, frozen along with the rest of the state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!stall_ext && stall_id && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!stall_ext && flush_id && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit: directed pipeline scenarios followed by
// randomized instruction streams, checked against a queue-based model of
// in-flight producers.
module tb_hazard_fwd_unit;

    localparam int N    = 2;
    localparam int LLAT = 1;
    localparam int SELW = $clog2(N + 1);

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [31:0]     inst_id = '0;
    logic            id_valid = 1'b0;
    logic            ex_taken = 1'b0;
    logic            stall_ext = 1'b0;
    logic            stall_id, flush_id;
    logic [SELW-1:0] rs1_fwd_sel, rs2_fwd_sel;
    logic            rs1_fwd_ld, rs2_fwd_ld;
`ifdef HAZARD_STATS_EN
    logic [31:0]     stall_cnt, flush_cnt;
`endif

    hazard_fwd_unit #(.NUM_FWD_STAGES(N), .LOAD_LAT(LLAT)) dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .id_valid(id_valid),
        .ex_taken(ex_taken), .stall_ext(stall_ext),
        .stall_id(stall_id), .flush_id(flush_id),
        .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
        .rs1_fwd_ld(rs1_fwd_ld), .rs2_fwd_ld(rs2_fwd_ld)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: producers in flight, youngest first (age 0 = in EX).
    typedef struct packed { logic v; logic [4:0] rd; logic ld; } ent_t;
    ent_t        m_sb[$];
    int          m_sel1, m_sel2;
    bit          m_ld1, m_ld2;
    int unsigned m_stall_cnt, m_flush_cnt;
    bit          obs_stall, obs_flush, exp_stall_last;

    function automatic void model_clear();
        m_sb.delete();
        for (int i = 0; i < N; i++) m_sb.push_back('0);
        m_sel1 = 0; m_sel2 = 0; m_ld1 = 0; m_ld2 = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endfunction

    // Youngest in-flight producer of register rs; age -1 when none
    function automatic void lookup(input logic [4:0] rs, input bit used,
                                   output int age, output bit is_ld);
        age = -1;
        is_ld = 0;
        if (!used || rs == 5'd0) return;
        for (int i = 0; i < m_sb.size(); i++) begin
            if (m_sb[i].v && m_sb[i].rd == rs) begin
                age = i;
                is_ld = m_sb[i].ld;
                return;
            end
        end
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] opc);
        return {7'b0, rs2, rs1, 3'b0, rd, opc};
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check registers
    task automatic step(input logic [31:0] inst, input bit idv, input bit taken, input bit sx);
        logic [6:0] opc;
        logic [4:0] f_rd, f_rs1, f_rs2;
        bit u1, u2, hr, lu1, lu2, es;
        int a1, a2;
        ent_t e;
        @(negedge clk);
        inst_id = inst; id_valid = idv; ex_taken = taken; stall_ext = sx;
        #1;
        opc = inst[6:0]; f_rd = inst[11:7]; f_rs1 = inst[19:15]; f_rs2 = inst[24:20];
        u1 = idv && !(opc inside {LUI, AUIPC, JAL});
        u2 = idv && (opc inside {OP, STORE, BRANCH});
        hr = !(opc inside {STORE, BRANCH, SYSTEM}) && f_rd != 5'd0;
        lookup(f_rs1, u1, a1, lu1);
        lookup(f_rs2, u2, a2, lu2);
        es = !taken && ((a1 >= 0 && lu1 && a1 < LLAT) || (a2 >= 0 && lu2 && a2 < LLAT));
        obs_stall = stall_id;
        obs_flush = flush_id;
        exp_stall_last = es;
        check_val("stall_id", stall_id, es);
        check_val("flush_id", flush_id, taken);
        if (!sx) begin
            if (taken || es) begin
                e = '0;
                m_sel1 = 0; m_sel2 = 0; m_ld1 = 0; m_ld2 = 0;
            end else begin
                e = '{v: idv && hr, rd: f_rd, ld: opc == LOAD};
                m_sel1 = (a1 >= 0) ? a1 + 1 : 0;
                m_sel2 = (a2 >= 0) ? a2 + 1 : 0;
                m_ld1  = (a1 >= 0) ? lu1 : 0;
                m_ld2  = (a2 >= 0) ? lu2 : 0;
            end
            m_sb.push_front(e);
            void'(m_sb.pop_back());
            if (es && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (taken && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        @(posedge clk);
        #1;
        check_val("rs1_fwd_sel", rs1_fwd_sel, m_sel1);
        check_val("rs2_fwd_sel", rs2_fwd_sel, m_sel2);
        check_val("rs1_fwd_ld", rs1_fwd_ld, m_ld1);
        check_val("rs2_fwd_ld", rs2_fwd_ld, m_ld2);
`ifdef HAZARD_STATS_EN
        check_val("stall_cnt", stall_cnt, m_stall_cnt);
        check_val("flush_cnt", flush_cnt, m_flush_cnt);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        ex_taken = 0; stall_ext = 0; id_valid = 0; inst_id = NOP;
        rst = 1'b0;
        #1;
        model_clear();
        check_val("rst_sel1", rs1_fwd_sel, 0);
        check_val("rst_sel2", rs2_fwd_sel, 0);
        check_val("rst_ld", {rs1_fwd_ld, rs2_fwd_ld}, 0);
        check_val("rst_stall", stall_id, 0);
`ifdef HAZARD_STATS_EN
        check_val("rst_cnt", stall_cnt | flush_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] cur;
        logic [6:0]  opcs[10];
        bit          hold, sx, tk;
        opcs = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM};

        do_reset();

        // back-to-back ALU dependency
        step(enc(5, 1, 2, OP), 1, 0, 0);
        step(enc(6, 5, 3, OP), 1, 0, 0);
        check_val("ex1_sel1", rs1_fwd_sel, 1);
        check_val("ex1_ld1", rs1_fwd_ld, 0);
        check_val("ex1_nostall", obs_stall, 0);

        // dependency two back, then three back
        step(enc(5, 1, 2, OP), 1, 0, 0);
        step(NOP, 1, 0, 0);
        step(enc(7, 4, 5, OP), 1, 0, 0);
        check_val("ex2_sel2", rs2_fwd_sel, 2);
        step(enc(5, 1, 2, OP), 1, 0, 0);
        step(NOP, 1, 0, 0);
        step(NOP, 1, 0, 0);
        step(enc(7, 4, 5, OP), 1, 0, 0);
        check_val("ex2_sel2_far", rs2_fwd_sel, 0);

        // load-use: one stall, then forward load data from stage 2
        step(enc(5, 1, 0, LOAD), 1, 0, 0);
        step(enc(6, 5, 5, OP), 1, 0, 0);
        check_val("lu_stall", obs_stall, 1);
        step(enc(6, 5, 5, OP), 1, 0, 0);
        check_val("lu_nostall", obs_stall, 0);
        check_val("lu_sel1", rs1_fwd_sel, 2);
        check_val("lu_sel2", rs2_fwd_sel, 2);
        check_val("lu_ld", {rs1_fwd_ld, rs2_fwd_ld}, 2'b11);

        // load-use coinciding with a taken branch: flush wins
        step(enc(5, 1, 0, LOAD), 1, 0, 0);
        step(enc(0, 5, 0, BRANCH), 1, 1, 0);
        check_val("fl_flush", obs_flush, 1);
        check_val("fl_stall", obs_stall, 0);
        check_val("fl_sel1", rs1_fwd_sel, 0);

        // x0 producer is never forwarded
        step(enc(0, 1, 2, OP), 1, 0, 0);
        step(enc(6, 0, 0, OP), 1, 0, 0);
        check_val("x0_sel", {rs1_fwd_sel, rs2_fwd_sel}, 0);

        // external freeze holds selects and scoreboard
        step(enc(5, 1, 2, OP), 1, 0, 0);
        step(enc(6, 5, 5, OP), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(enc(7, 1, 2, OP), 1, i == 1, 1);
        check_val("sx_sel1", rs1_fwd_sel, 1);
        check_val("sx_sel2", rs2_fwd_sel, 1);
        step(enc(7, 5, 5, OP), 1, 0, 0);
        check_val("sx_after", rs1_fwd_sel, 2);

        // reset in the middle of a load-use stall
        step(enc(5, 1, 0, LOAD), 1, 0, 0);
        @(negedge clk);
        inst_id = enc(6, 5, 5, OP); id_valid = 1; ex_taken = 0; stall_ext = 0;
        #1;
        check_val("rs_stall_pre", stall_id, 1);
        rst = 1'b0;
        #1;
        check_val("rs_stall_post", stall_id, 0);
        check_val("rs_sel", {rs1_fwd_sel, rs2_fwd_sel}, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        step(enc(6, 5, 5, OP), 1, 0, 0);

        // randomized streams; ID holds its instruction while stalled
        cur = NOP;
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) begin
                do_reset();
                hold = 0;
            end
            if (!hold)
                cur = {$urandom_range(0, 127) == 0 ? 7'h7f : 7'($urandom()),
                       5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                       3'($urandom()), 5'($urandom_range(0, 6)),
                       opcs[$urandom_range(0, 9)]};
            sx = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 5) == 0);
            step(cur, $urandom_range(0, 7) != 0, tk, sx);
            hold = sx || exp_stall_last;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
